// File: rtl/home_pkg.sv
// Shared types and default constants for the sensor scan sequencer.
package home_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } scan_state_t;

  localparam int unsigned DEF_N_CH         = 4;
  localparam int unsigned DEF_SEL_W        = 2;
  localparam int unsigned DEF_SETTLE_CYC   = 3;
  localparam int unsigned DEF_DEBOUNCE_CNT = 4;

endpackage

// File: rtl/sensor_scan_demux_debounce_cell.sv
// debounce_cell: one channel's debounce counter and debounced state bit.
module debounce_cell
  import home_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic sample,
  output logic state,
  output logic changed
);

  localparam int unsigned   CW       = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      state   <= 1'b0;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (sample_en) begin
        if (sample == state) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          state   <= ~state;
          cnt     <= '0;
          changed <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sensor_scan_demux.sv
// Round-robin mux scan sequencer with per-channel debounce and change pulses.
// Optional irq/irq_clr interface is built when SCAN_IRQ_EN is defined.
module sensor_scan_demux
  import home_pkg::*;
#(
  parameter int unsigned N_CH         = DEF_N_CH,
  parameter int unsigned SEL_W        = DEF_SEL_W,
  parameter int unsigned SETTLE_CYC   = DEF_SETTLE_CYC,
  parameter int unsigned DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [SEL_W-1:0] mux_sel,
  input  logic             mux_in,
  output logic [N_CH-1:0]  ch_state,
  output logic [N_CH-1:0]  ch_changed,
  output logic             scan_done
`ifdef SCAN_IRQ_EN
  ,
  output logic             irq,
  input  logic             irq_clr
`endif
);

  localparam int unsigned    SCW         = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC - 1);
  localparam logic [SEL_W-1:0] CH_LAST   = SEL_W'(N_CH - 1);

  scan_state_t      state, state_d;
  logic [SEL_W-1:0] ch, ch_d;
  logic [SCW-1:0]   scnt, scnt_d;
  logic             done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ch        <= '0;
      scnt      <= '0;
      scan_done <= 1'b0;
    end else begin
      state     <= state_d;
      ch        <= ch_d;
      scnt      <= scnt_d;
      scan_done <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    ch_d    = ch;
    scnt_d  = scnt;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) begin
          state_d = SETTLE;
          scnt_d  = '0;
        end
      end
      SETTLE: begin
        if (scnt == SETTLE_LAST) state_d = SAMPLE;
        else                     scnt_d  = scnt + 1'b1;
      end
      SAMPLE: begin
        state_d = SETTLE;
        scnt_d  = '0;
        if (ch == CH_LAST) begin
          ch_d   = '0;
          done_d = 1'b1;
        end else begin
          ch_d = ch + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Disable overrides the transition only; the SAMPLE strobe below is state-based,
    // so a sample already in progress still reaches its debounce cell.
    if (!en) begin
      state_d = IDLE;
      ch_d    = '0;
    end
  end

  // ch is held at 0 outside a scan, so it doubles as the select output.
  assign mux_sel = ch;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_cell #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .sample_en((state == SAMPLE) && (ch == SEL_W'(i))),
      .sample   (mux_in),
      .state    (ch_state[i]),
      .changed  (ch_changed[i])
    );
  end

`ifdef SCAN_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              irq <= 1'b0;
    else if (|ch_changed) irq <= 1'b1;
    else if (irq_clr)     irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_sensor_scan_demux.sv
// Scoreboard bench for sensor_scan_demux: scan-level reference model feeds
// expected scan states and change pulses to a free-running monitor.
module tb_sensor_scan_demux;
  import home_pkg::*;

  localparam int unsigned N_CH         = 4;
  localparam int unsigned SEL_W        = 2;
  localparam int unsigned SETTLE_CYC   = 3;
  localparam int unsigned DEBOUNCE_CNT = 4;
  localparam int unsigned CPC          = SETTLE_CYC + 1;
  localparam int unsigned LIMIT        = CPC * N_CH * 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             mux_in;
  logic [SEL_W-1:0] mux_sel;
  logic [N_CH-1:0]  ch_state;
  logic [N_CH-1:0]  ch_changed;
  logic             scan_done;
`ifdef SCAN_IRQ_EN
  logic             irq;
  logic             irq_clr;
`endif

  logic [N_CH-1:0]  chan_val;
  logic [N_CH-1:0]  exp_state_q[$];
  logic [N_CH-1:0]  exp_chg_q[$];
  logic [N_CH-1:0]  mst;
  int unsigned      mcnt[N_CH];
  int unsigned      total = 0;
  int unsigned      bad = 0;

  always #5 clk = ~clk;

  // External mux: the bench holds one level per channel and routes the selected one.
  always_comb mux_in = chan_val[mux_sel];

  sensor_scan_demux #(
    .N_CH        (N_CH),
    .SEL_W       (SEL_W),
    .SETTLE_CYC  (SETTLE_CYC),
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mux_sel   (mux_sel),
    .mux_in    (mux_in),
    .ch_state  (ch_state),
    .ch_changed(ch_changed),
    .scan_done (scan_done)
`ifdef SCAN_IRQ_EN
    ,
    .irq       (irq),
    .irq_clr   (irq_clr)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scan-level debounce rule: a channel flips after DEBOUNCE_CNT consecutive differing samples.
  task automatic model_apply(input logic [N_CH-1:0] v, input int unsigned nch);
    logic [N_CH-1:0] m;
    for (int unsigned c = 0; c < nch; c++) begin
      if (v[c] == mst[c]) begin
        mcnt[c] = 0;
      end else if (mcnt[c] + 1 == DEBOUNCE_CNT) begin
        mst[c]  = ~mst[c];
        mcnt[c] = 0;
        m       = '0;
        m[c]    = 1'b1;
        exp_chg_q.push_back(m);
      end else begin
        mcnt[c] = mcnt[c] + 1;
      end
    end
  endtask

  task automatic model_reset();
    mst = '0;
    for (int unsigned c = 0; c < N_CH; c++) mcnt[c] = 0;
  endtask

  task automatic wait_done(input string name);
    for (int unsigned n = 0; n < LIMIT; n++) begin
      @(negedge clk);
      if (scan_done) break;
    end
    check(name, 32'(scan_done), 32'd1);
  endtask

  task automatic run_scan(input logic [N_CH-1:0] v);
    chan_val = v;
    model_apply(v, N_CH);
    exp_state_q.push_back(mst);
    en = 1'b1;
    wait_done("scan_done_timeout");
  endtask

  function automatic logic [N_CH-1:0] drift(input logic [N_CH-1:0] prev);
    logic [N_CH-1:0] r;
    r = prev;
    for (int unsigned c = 0; c < N_CH; c++)
      if ($urandom_range(0, 3) == 0) r[c] = ~r[c];
    return r;
  endfunction

  // Monitor: pops an expectation whenever the DUT presents a scan_done or change pulse.
  always @(negedge clk) begin
    logic [N_CH-1:0] e;
    if (!rst) begin
      if (scan_done) begin
        if (exp_state_q.size() == 0) check("unexpected_scan_done", 32'd1, 32'd0);
        else begin
          e = exp_state_q.pop_front();
          check("scan_state", 32'(ch_state), 32'(e));
        end
      end
      if (ch_changed != '0) begin
        if (exp_chg_q.size() == 0) check("unexpected_ch_changed", 32'(ch_changed), 32'd0);
        else begin
          e = exp_chg_q.pop_front();
          check("ch_changed", 32'(ch_changed), 32'(e));
        end
      end
    end
  end

`ifdef SCAN_IRQ_EN
  logic exp_irq;
  initial begin
    irq_clr = 1'b0;
    forever begin
      @(negedge clk);
      irq_clr = ($urandom_range(0, 2) == 0);
    end
  end
  initial begin
    exp_irq = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) exp_irq = 1'b0;
      else begin
        check("irq", 32'(irq), 32'(exp_irq));
        if (ch_changed != '0) exp_irq = 1'b1;
        else if (irq_clr)     exp_irq = 1'b0;
      end
    end
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [N_CH-1:0] v;
    rst      = 1'b1;
    en       = 1'b0;
    chan_val = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_mux_sel",    32'(mux_sel),    32'd0);
    check("rst_ch_state",   32'(ch_state),   32'd0);
    check("rst_ch_changed", 32'(ch_changed), 32'd0);
    check("rst_scan_done",  32'(scan_done),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Round-robin select timing over two full scans of quiet inputs.
    for (int unsigned s = 0; s < 2; s++) begin
      model_apply('0, N_CH);
      exp_state_q.push_back(mst);
    end
    en = 1'b1;
    for (int unsigned k = 1; k <= 2 * N_CH * CPC; k++) begin
      @(negedge clk);
      check("mux_sel_seq", 32'(mux_sel), ((k - 1) / CPC) % N_CH);
      check("scan_done_seq", 32'(scan_done), 32'(k == N_CH * CPC + 1));
    end
    wait_done("scan2_timeout");

    // Channel 2 held high flips on the DEBOUNCE_CNT-th scan.
    for (int unsigned s = 0; s < DEBOUNCE_CNT; s++) run_scan(4'b0100);
    check("ch2_set", 32'(ch_state), 32'h4);

    // Short glitch on channel 1 must not flip it, and its count must clear.
    for (int unsigned s = 0; s < DEBOUNCE_CNT - 1; s++) run_scan(4'b0110);
    run_scan(4'b0100);
    for (int unsigned s = 0; s < DEBOUNCE_CNT - 1; s++) run_scan(4'b0110);
    run_scan(4'b0100);
    check("glitch_ignored", 32'(ch_state), 32'h4);

    // Disable during the last channel's settle.
    v = 4'b1011;
    chan_val = v;
    model_apply(v, N_CH - 1);
    for (int unsigned n = 0; n < LIMIT; n++) begin
      @(negedge clk);
      if (mux_sel == SEL_W'(N_CH - 1)) break;
    end
    check("reach_last_ch", 32'(mux_sel), N_CH - 1);
    en = 1'b0;
    @(negedge clk);
    check("idle_mux_sel", 32'(mux_sel), 32'd0);
    repeat (4) @(negedge clk);
    check("idle_mux_sel_hold", 32'(mux_sel), 32'd0);
    check("idle_state_kept", 32'(ch_state), 32'(mst));
    run_scan(v);

    // Randomized drifting inputs.
    for (int unsigned s = 0; s < 20; s++) begin
      v = drift(v);
      run_scan(v);
    end

    // Reset in the SAMPLE cycle that would complete a channel-0 flip.
    v = mst;
    v[2] = 1'b1;
    for (int unsigned s = 0; s < DEBOUNCE_CNT; s++) run_scan(v);
    v = mst;
    run_scan(v);
    v[0] = ~mst[0];
    for (int unsigned s = 0; s < DEBOUNCE_CNT - 1; s++) run_scan(v);
    repeat (SETTLE_CYC) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ch_state",   32'(ch_state),   32'd0);
    check("midrst_ch_changed", 32'(ch_changed), 32'd0);
    check("midrst_scan_done",  32'(scan_done),  32'd0);
    check("midrst_mux_sel",    32'(mux_sel),    32'd0);
    en = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int unsigned n = 0; n < 6; n++) begin
      @(negedge clk);
      check("no_pulse_after_rst", 32'({ch_state, ch_changed}), 32'd0);
    end

    for (int unsigned s = 0; s < 12; s++) begin
      v = drift(v);
      run_scan(v);
    end

    @(negedge clk);
    check("pending_scan_states", exp_state_q.size(), 32'd0);
    check("pending_changes",     exp_chg_q.size(),   32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
